// File: rtl/egress_byte_serializer_pkg.sv
// Shared constants for the egress byte serializer: sync byte, word geometry and FSM encodings.
// The sync-byte state ST_SYNC is only used when EGRESS_SYNC_EN is defined.
package egress_byte_serializer_pkg;

    localparam logic [7:0]  EGRESS_SYNC_BYTE      = 8'hA5;
    localparam int unsigned EGRESS_BYTES_PER_WORD = 4;

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_SYNC  = 2'd1;
    localparam logic [1:0]  ST_SHIFT = 2'd2;

endpackage

// File: rtl/egress_word_fifo.sv
// Synchronous word FIFO with registered head word, full/empty flags and fill level.
// Push when full and pop when empty are ignored; the caller gates them anyway.
module egress_word_fifo
    import egress_byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int unsigned LW = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_full;
    logic                  r_empty;
    logic [WIDTH-1:0]      r_rd_data;

    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
    logic [LW-1:0]         w_level_nxt;
    logic [WIDTH-1:0]      w_head_nxt;

    // Head word is precomputed so the read data is a register, including write-through on empty.
    always_comb begin
        w_push       = i_push & ~r_full;
        w_pop        = i_pop & ~r_empty;
        w_rd_ptr_nxt = r_rd_ptr + DEPTH_LOG2'(w_pop);
        w_level_nxt  = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = i_wdata;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_rd_data <= '0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + DEPTH_LOG2'(w_push);
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_level   <= w_level_nxt;
            r_full    <= (w_level_nxt == LW'(DEPTH));
            r_empty   <= (w_level_nxt == '0);
            r_rd_data <= w_head_nxt;
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_level   = r_level;

endmodule

// File: rtl/egress_byte_serializer.sv
// Buffers result words in a small FIFO and shifts them out MSB byte first, one byte per clock.
// Optional feature: define EGRESS_SYNC_EN to prefix every word with one sync byte.
module egress_byte_serializer
    import egress_byte_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8 * EGRESS_BYTES_PER_WORD,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       Clk,
    input  logic                       ARst,
    input  logic [DATA_WIDTH-1:0]      WriteData,
    input  logic                       WriteDataValid,
    output logic                       Ready,
    output logic [7:0]                 Data,
    output logic                       DataValid,
    output logic [FIFO_DEPTH_LOG2:0]   Level,
    output logic                       Overflow
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [7:0]            r_data;
    logic                  r_valid;
    logic                  r_overflow;

    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [7:0]            w_data_nxt;
    logic                  w_valid_nxt;
    logic                  w_load;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_push = WriteDataValid & ~w_full;

    egress_word_fifo #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .i_clk     (Clk),
        .i_rst     (ARst),
        .i_push    (w_push),
        .i_wdata   (WriteData),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (Level)
    );

    // Next state and outputs; r_cnt counts bytes still to follow the one on Data.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_load      = 1'b0;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_load = ~w_empty;
            end
`ifdef EGRESS_SYNC_EN
            ST_SYNC: begin
                w_data_nxt  = r_shift[DATA_WIDTH-1 -: 8];
                w_shift_nxt = r_shift << 8;
                w_cnt_nxt   = CNT_W'(NB - 1);
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
`endif
            ST_SHIFT: begin
                if (r_cnt != '0) begin
                    w_data_nxt  = r_shift[DATA_WIDTH-1 -: 8];
                    w_shift_nxt = r_shift << 8;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_valid_nxt = 1'b1;
                end else if (!w_empty) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Pop the head word; back-to-back with the previous word's last byte, no bubble.
        if (w_load) begin
            w_pop       = 1'b1;
            w_valid_nxt = 1'b1;
`ifdef EGRESS_SYNC_EN
            w_state_nxt = ST_SYNC;
            w_data_nxt  = EGRESS_SYNC_BYTE;
            w_shift_nxt = w_head;
`else
            w_state_nxt = ST_SHIFT;
            w_data_nxt  = w_head[DATA_WIDTH-1 -: 8];
            w_shift_nxt = w_head << 8;
            w_cnt_nxt   = CNT_W'(NB - 1);
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (ARst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_overflow <= r_overflow | (WriteDataValid & w_full);
        end
    end

    assign Ready     = ~w_full;
    assign Data      = r_data;
    assign DataValid = r_valid;
    assign Overflow  = r_overflow;

endmodule

// File: tb/tb_egress_byte_serializer.sv
// Bench for egress_byte_serializer: queue-based byte-stream model plus directed literal checks.
// Honours EGRESS_SYNC_EN the same way as the design.
module tb_egress_byte_serializer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DLOG2 = 2;

    typedef logic [7:0] byteq_t[$];

    logic          Clk = 1'b0;
    logic          ARst;
    logic [DW-1:0] WriteData;
    logic          WriteDataValid;
    logic          Ready;
    logic [7:0]    Data;
    logic          DataValid;
    logic [DLOG2:0] Level;
    logic          Overflow;

    int checks = 0;
    int errors = 0;

    egress_byte_serializer #(
        .DATA_WIDTH      (DW),
        .FIFO_DEPTH      (DEPTH),
        .FIFO_DEPTH_LOG2 (DLOG2)
    ) dut (
        .Clk            (Clk),
        .ARst           (ARst),
        .WriteData      (WriteData),
        .WriteDataValid (WriteDataValid),
        .Ready          (Ready),
        .Data           (Data),
        .DataValid      (DataValid),
        .Level          (Level),
        .Overflow       (Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic byteq_t word_bytes(input logic [31:0] w);
        byteq_t q;
        q = {};
`ifdef EGRESS_SYNC_EN
        q.push_back(8'hA5);
`endif
        for (int i = 3; i >= 0; i--) q.push_back(w[8*i +: 8]);
        return q;
    endfunction

    // Model: a word queue feeding a byte queue; the pins drain one byte per clock.
    logic [31:0] mq[$];
    byteq_t      bq;
    logic [7:0]  m_data  = 8'h00;
    logic        m_valid = 1'b0;
    logic        m_ovf   = 1'b0;

    always @(posedge Clk) begin
        bit acc;
        if (ARst) begin
            mq.delete();
            bq.delete();
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            acc = WriteDataValid && (mq.size() < DEPTH);
            if (WriteDataValid && !acc) m_ovf = 1'b1;
            if (bq.size() != 0) begin
                m_data  = bq.pop_front();
                m_valid = 1'b1;
            end else if (mq.size() != 0) begin
                bq      = word_bytes(mq.pop_front());
                m_data  = bq.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (acc) mq.push_back(WriteData);
        end
    end

    // Every-cycle compare against the model, plus capture of the valid byte stream.
    bit         cmp_en = 1'b0;
    int         cyc = 0;
    byteq_t     got;
    int         gotc[$];
    int         lvl_peak = 0;

    always @(negedge Clk) begin
        cyc++;
        if (cmp_en) begin
            chk("cyc_valid", 32'(DataValid), 32'(m_valid));
            chk("cyc_data", 32'(Data), 32'(m_data));
            chk("cyc_level", 32'(Level), 32'(mq.size()));
            chk("cyc_ready", 32'(Ready), 32'(mq.size() != DEPTH));
            chk("cyc_overflow", 32'(Overflow), 32'(m_ovf));
            if (DataValid) begin
                got.push_back(Data);
                gotc.push_back(cyc);
            end
            if (int'(Level) > lvl_peak) lvl_peak = int'(Level);
        end
    end

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (mq.size() == 0 && bq.size() == 0 && !m_valid) begin
                idle = 1'b1;
                break;
            end
        end
        chk("drain_idle", 32'(idle), 32'd1);
        @(negedge Clk);
    endtask

    task automatic cmp_stream(input string name, input byteq_t act, input byteq_t exp);
        chk({name, "_len"}, 32'(act.size()), 32'(exp.size()));
        for (int i = 0; i < act.size() && i < exp.size(); i++)
            chk($sformatf("%s_b%0d", name, i), 32'(act[i]), 32'(exp[i]));
    endtask

    task automatic clear_capture();
        got.delete();
        gotc.delete();
        lvl_peak = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        byteq_t e;
        logic [31:0] words[$];

        ARst = 1'b1;
        WriteDataValid = 1'b0;
        WriteData = '0;
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_valid", 32'(DataValid), 32'd0);
        chk("rst_data", 32'(Data), 32'h00);
        chk("rst_level", 32'(Level), 32'd0);
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_overflow", 32'(Overflow), 32'd0);
        ARst = 1'b0;
        cmp_en = 1'b1;
        @(negedge Clk);

        // Single word, first byte one edge after the write.
        clear_capture();
        WriteData = 32'h12345678;
        WriteDataValid = 1'b1;
        @(negedge Clk);
        WriteDataValid = 1'b0;
        chk("t1_not_yet_valid", 32'(DataValid), 32'd0);
        chk("t1_level_after_push", 32'(Level), 32'd1);
        @(negedge Clk);
        chk("t1_first_valid", 32'(DataValid), 32'd1);
`ifdef EGRESS_SYNC_EN
        chk("t1_first_byte", 32'(Data), 32'hA5);
`else
        chk("t1_first_byte", 32'(Data), 32'h12);
`endif
        drain();
        e = '{8'h12, 8'h34, 8'h56, 8'h78};
`ifdef EGRESS_SYNC_EN
        e.push_front(8'hA5);
`endif
        cmp_stream("t1_stream", got, e);

        // Two words one clock apart stream without a gap.
        clear_capture();
        WriteData = 32'hDEADBEEF;
        WriteDataValid = 1'b1;
        @(negedge Clk);
        WriteData = 32'h0BADF00D;
        @(negedge Clk);
        WriteDataValid = 1'b0;
        drain();
`ifdef EGRESS_SYNC_EN
        e = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
        chk("t2_span", 32'(gotc[gotc.size()-1] - gotc[0]), 32'd9);
`else
        e = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
        chk("t2_span", 32'(gotc[gotc.size()-1] - gotc[0]), 32'd7);
`endif
        cmp_stream("t2_stream", got, e);
        chk("t2_level_peak", 32'(lvl_peak), 32'd1);

        // Write burst ignoring Ready: overflow and exactly the dropped words vanish.
        clear_capture();
        for (int k = 0; k < 8; k++) begin
            WriteData = 32'hA0B0C0D0 + 32'(k);
            WriteDataValid = 1'b1;
            @(negedge Clk);
            if (k == 4) begin
                chk("t3_ready_low", 32'(Ready), 32'd0);
                chk("t3_level_full", 32'(Level), 32'd4);
            end
        end
        WriteDataValid = 1'b0;
        chk("t3_overflow", 32'(Overflow), 32'd1);
        drain();
`ifdef EGRESS_SYNC_EN
        words = '{32'hA0B0C0D0, 32'hA0B0C0D1, 32'hA0B0C0D2, 32'hA0B0C0D3, 32'hA0B0C0D4, 32'hA0B0C0D7};
`else
        words = '{32'hA0B0C0D0, 32'hA0B0C0D1, 32'hA0B0C0D2, 32'hA0B0C0D3, 32'hA0B0C0D4, 32'hA0B0C0D6};
`endif
        e = {};
        foreach (words[i]) e = {e, word_bytes(words[i])};
        cmp_stream("t3_stream", got, e);
        chk("t3_overflow_sticky", 32'(Overflow), 32'd1);

        // Reset mid-word discards the remainder and clears Overflow.
        clear_capture();
        WriteData = 32'hCAFEF00D;
        WriteDataValid = 1'b1;
        @(negedge Clk);
        WriteDataValid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("t4_overflow_before", 32'(Overflow), 32'd1);
        ARst = 1'b1;
        @(negedge Clk);
        ARst = 1'b0;
        chk("t4_valid", 32'(DataValid), 32'd0);
        chk("t4_level", 32'(Level), 32'd0);
        chk("t4_ready", 32'(Ready), 32'd1);
        chk("t4_overflow", 32'(Overflow), 32'd0);
        for (int i = 0; i < 10; i++) @(negedge Clk);
`ifdef EGRESS_SYNC_EN
        e = '{8'hA5, 8'hCA};
`else
        e = '{8'hCA, 8'hFE};
`endif
        cmp_stream("t4_stream", got, e);

        // Single word 01020304 (sync byte first when enabled).
        clear_capture();
        WriteData = 32'h01020304;
        WriteDataValid = 1'b1;
        @(negedge Clk);
        WriteDataValid = 1'b0;
        drain();
`ifdef EGRESS_SYNC_EN
        e = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
        chk("t5_span", 32'(gotc[gotc.size()-1] - gotc[0]), 32'd4);
`else
        e = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk("t5_span", 32'(gotc[gotc.size()-1] - gotc[0]), 32'd3);
`endif
        cmp_stream("t5_stream", got, e);

        // Pointer wrap: three FIFO depths of words, written only while Ready.
        clear_capture();
        words = {};
        for (int k = 0; k < 3 * DEPTH; k++) begin
            int t;
            t = 0;
            WriteDataValid = 1'b0;
            while (!Ready && t < 50) begin
                @(negedge Clk);
                t++;
            end
            chk("t6_ready_wait", 32'(t < 50), 32'd1);
            WriteData = 32'h30313233 + 32'(k) * 32'h04040404;
            words.push_back(WriteData);
            WriteDataValid = 1'b1;
            @(negedge Clk);
        end
        WriteDataValid = 1'b0;
        drain();
        e = {};
        foreach (words[i]) e = {e, word_bytes(words[i])};
        cmp_stream("t6_stream", got, e);
        chk("t6_level", 32'(Level), 32'd0);
        chk("t6_overflow", 32'(Overflow), 32'd0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
